// File: rtl/m_ff_sync_filt.sv
// Multi-channel input synchroniser with per-channel stability filter and
// registered rise/fall edge pulses on every accepted transition.
module m_ff_sync_filt #(
   parameter int unsigned      WIDTH    = 4,
   parameter int unsigned      NUM_FF   = 3,
   parameter int unsigned      FILT_CNT = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_filt_en,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_data,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   localparam int unsigned      CNT_W    = $clog2(FILT_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

   logic [WIDTH-1:0] sync_q [NUM_FF];
   logic [WIDTH-1:0] sync_last;
   logic [CNT_W-1:0] cnt_q  [WIDTH];
   logic [CNT_W-1:0] cnt_d  [WIDTH];
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;

   assign sync_last = sync_q[NUM_FF-1];

   // Synchroniser chain; every stage resets to RST_VAL so release causes no glitch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(NUM_FF); k++) begin
            sync_q[k] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= i_data;
         for (int k = 1; k < int'(NUM_FF); k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Next filtered level: accept a new level after FILT_CNT consecutive disagreeing cycles
   always_comb begin
      data_d = data_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         cnt_d[i] = '0;
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (!i_filt_en) begin
            data_d[i] = sync_last[i];
         end else if (sync_last[i] != data_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               data_d[i] = sync_last[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Filtered level, counters and edge pulses updated together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         data_q <= data_d;
         rise_q <= data_d & ~data_q;
         fall_q <= ~data_d & data_q;
         for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign o_sync = sync_last;
   assign o_data = data_q;
   assign o_rise = rise_q;
   assign o_fall = fall_q;

endmodule

// File: tb/tb_m_ff_sync_filt.sv
// Bench for m_ff_sync_filt: directed timing checks plus a per-cycle
// scoreboard fed by a reference model and drained by a monitor.
module tb_m_ff_sync_filt;

   localparam int unsigned W   = 4;
   localparam int unsigned NFF = 3;
   localparam int unsigned FC  = 4;
   localparam logic [W-1:0] RST = 4'b0101;

   logic         clk       = 1'b0;
   logic         clk_en    = 1'b0;
   logic         rst_n     = 1'b1;
   logic [W-1:0] i_data    = 4'b1010;
   logic         i_filt_en = 1'b1;
   logic [W-1:0] o_sync;
   logic [W-1:0] o_data;
   logic [W-1:0] o_rise;
   logic [W-1:0] o_fall;

   int n_checks = 0;
   int n_err    = 0;

   logic [4*W-1:0] exp_q [$];

   m_ff_sync_filt #(
      .WIDTH   (W),
      .NUM_FF  (NFF),
      .FILT_CNT(FC),
      .RST_VAL (RST)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_data   (i_data),
      .i_filt_en(i_filt_en),
      .o_sync   (o_sync),
      .o_data   (o_data),
      .o_rise   (o_rise),
      .o_fall   (o_fall)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic edge_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: tracks the run length of cycles where the synced level disagrees
   logic [W-1:0] m_ch [NFF];
   logic [W-1:0] m_data, m_rise, m_fall, m_nd;
   int           m_run [W];

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            for (int k = 0; k < int'(NFF); k++) m_ch[k] = RST;
            m_data = RST;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < int'(W); i++) m_run[i] = 0;
         end else begin
            m_nd = m_data;
            for (int i = 0; i < int'(W); i++) begin
               if (!i_filt_en) begin
                  m_nd[i]  = m_ch[NFF-1][i];
                  m_run[i] = 0;
               end else if (m_ch[NFF-1][i] != m_data[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] >= int'(FC)) begin
                     m_nd[i]  = m_ch[NFF-1][i];
                     m_run[i] = 0;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_rise = m_nd & ~m_data;
            m_fall = ~m_nd & m_data;
            m_data = m_nd;
            for (int k = int'(NFF) - 1; k > 0; k--) m_ch[k] = m_ch[k-1];
            m_ch[0] = i_data;
         end
         exp_q.push_back({m_ch[NFF-1], m_data, m_rise, m_fall});
      end
   end

   // Monitor: one expected response per clock edge
   initial begin
      logic [4*W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL scoreboard: no expected entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("cycle", {o_sync, o_data, o_rise, o_fall}, e);
            chk("rise_fall_excl", 16'(o_rise & o_fall), 16'h0);
         end
      end
   end

   // Pulse ch1 for len input cycles and tally what comes out
   task automatic glitch(input int len, input int exp_d, input int exp_r, input int exp_f);
      int cs = 0, cd = 0, cr = 0, cf = 0;
      i_data = 4'b0011;
      for (int k = 1; k <= 16; k++) begin
         edge_n(1);
         cs += int'(o_sync[1]);
         cd += int'(o_data[1]);
         cr += int'(o_rise[1]);
         cf += int'(o_fall[1]);
         if (k == len) i_data = 4'b0001;
      end
      chk("glitch_sync_len", 16'(cs), 16'(len));
      chk("glitch_data_len", 16'(cd), 16'(exp_d));
      chk("glitch_rises",    16'(cr), 16'(exp_r));
      chk("glitch_falls",    16'(cf), 16'(exp_f));
      chk("glitch_other_ch", 16'(o_data), 16'h1);
   endtask

   initial begin
      // Asynchronous reset with no clock running
      #3 rst_n = 1'b0;
      #1;
      chk("rst_sync", 16'(o_sync), 16'h5);
      chk("rst_data", 16'(o_data), 16'h5);
      chk("rst_rise", 16'(o_rise), 16'h0);
      chk("rst_fall", 16'(o_fall), 16'h0);
      #4 clk_en = 1'b1;
      repeat (5) begin
         edge_n(1);
         chk("rst_hold", {8'h0, o_sync, o_data}, 16'h55);
      end
      i_data = 4'b0000;
      #3 rst_n = 1'b1;
      edge_n(12);
      chk("settle_zero", 16'(o_data), 16'h0);

      // Step on ch0
      i_data = 4'b0001;
      edge_n(2);
      chk("step_sync_e2", 16'(o_sync), 16'h0);
      edge_n(1);
      chk("step_sync_e3", 16'(o_sync), 16'h1);
      edge_n(3);
      chk("step_data_e6", {8'h0, o_data, o_rise}, 16'h00);
      edge_n(1);
      chk("step_data_e7", {o_data, o_rise, o_fall, 4'h0}, 16'h1100);
      edge_n(1);
      chk("step_data_e8", {o_data, o_rise, o_fall, 4'h0}, 16'h1000);

      // Glitches on ch1: 3 cycles rejected, 4 cycles accepted
      glitch(3, 0, 0, 0);
      glitch(4, 4, 1, 1);

      // Bounce on ch3: synced sequence 1,1,0,1,1,1,1
      i_data = 4'b1001;
      edge_n(2);
      i_data = 4'b0001;
      edge_n(1);
      i_data = 4'b1001;
      for (int k = 4; k <= 9; k++) begin
         edge_n(1);
         chk("bounce_hold", {8'h0, o_data, o_rise}, 16'h10);
      end
      edge_n(1);
      chk("bounce_rise", {8'h0, o_data, o_rise}, 16'h98);
      i_data = 4'b0001;
      edge_n(12);
      chk("bounce_settle", 16'(o_data), 16'h1);

      // Bypass: ch2 step appears after NUM_FF+1 edges
      i_filt_en = 1'b0;
      i_data    = 4'b0101;
      edge_n(3);
      chk("bypass_e3", {8'h0, o_data, o_rise}, 16'h10);
      edge_n(1);
      chk("bypass_e4", {8'h0, o_data, o_rise}, 16'h54);
      i_filt_en = 1'b1;
      edge_n(2);

      // Filter disabled mid-count on ch2 (count is 2 after edge 5)
      i_data = 4'b0001;
      edge_n(5);
      chk("mode_e5", {8'h0, o_data, o_fall}, 16'h50);
      i_filt_en = 1'b0;
      edge_n(1);
      chk("mode_e6", {8'h0, o_data, o_fall}, 16'h14);
      i_filt_en = 1'b1;
      edge_n(2);

      // Reset while ch1 is mid-count; ch1 reset bit is 0 so it can rise afterwards
      i_data = 4'b0011;
      edge_n(5);
      #3 rst_n = 1'b0;
      #1;
      chk("rstmid_sync", 16'(o_sync), 16'h5);
      chk("rstmid_data", 16'(o_data), 16'h5);
      chk("rstmid_pulse", {8'h0, o_rise, o_fall}, 16'h00);
      edge_n(2);
      #3 rst_n = 1'b1;
      edge_n(6);
      chk("rstmid_e6", {4'h0, o_data, o_rise, o_fall}, 16'h0500);
      edge_n(1);
      chk("rstmid_e7", {4'h0, o_data, o_rise, o_fall}, 16'h0324);

      // Random levels with occasional filter enable toggles
      for (int c = 0; c < 1000; c++) begin
         edge_n(1);
         for (int i = 0; i < int'(W); i++) begin
            if ($urandom_range(0, 4) == 0) i_data[i] = ~i_data[i];
         end
         if ($urandom_range(0, 39) == 0) i_filt_en = ~i_filt_en;
      end
      i_filt_en = 1'b1;
      edge_n(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
